// File: rtl/serial_frame_rx_if.sv
// Output handshake bundle for serial_frame_rx.
// The receiver drives the word and valid; the consumer drives ready.
interface serial_frame_rx_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] out;
    logic             out_perr;
    logic             out_val;
    logic             out_rdy;

    modport master (
        output out,
        output out_perr,
        output out_val,
        input  out_rdy
    );

    modport slave (
        input  out,
        input  out_perr,
        input  out_val,
        output out_rdy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, NBITS data LSB first, even parity, stop.
// Good frames go to a one-entry val/rdy output; losses are flagged and counted.
module serial_frame_rx #(
    parameter int NBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_,
    serial_frame_rx_if.master  deq,
    output logic               frame_err,
    output logic               overrun,
    output logic [7:0]         drop_count
);
    localparam int CW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] sreg_q, sreg_d;
    logic             perr_q, perr_d;
    logic [NBITS-1:0] out_q, out_d;
    logic             operr_q, operr_d;
    logic             val_q, val_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;
    logic [7:0]       drop_q, drop_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            perr_q  <= 1'b0;
            out_q   <= '0;
            operr_q <= 1'b0;
            val_q   <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            perr_q  <= perr_d;
            out_q   <= out_d;
            operr_q <= operr_d;
            val_q   <= val_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        perr_d  = perr_q;
        out_d   = out_q;
        operr_d = operr_q;
        val_d   = val_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        drop_d  = drop_q;

        if (val_q && deq.out_rdy) begin
            val_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!in_) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    sreg_d  = '0;
                end
            end
            DATA: begin
                sreg_d = sreg_q | (NBITS'(in_) << cnt_q);
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                perr_d  = (^sreg_q) ^ in_;
                state_d = STOP;
            end
            STOP: begin
                if (in_) begin
                    state_d = IDLE;
                    // A same-cycle accept frees the slot for the new word
                    if (!val_q || deq.out_rdy) begin
                        out_d   = sreg_q;
                        operr_d = perr_q;
                        val_d   = 1'b1;
                    end else begin
                        ov_d = 1'b1;
                    end
                end else begin
                    fe_d    = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (in_) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((fe_d || ov_d) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    assign deq.out      = out_q;
    assign deq.out_perr = operr_q;
    assign deq.out_val  = val_q;
    assign frame_err    = fe_q;
    assign overrun      = ov_q;
    assign drop_count   = drop_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with a queue scoreboard
// and an independent monitor on the output handshake.
module tb_serial_frame_rx;
    logic       clk;
    logic       reset;
    logic       in_;
    logic       frame_err;
    logic       overrun;
    logic [7:0] drop_count;

    serial_frame_rx_if #(.NBITS(8)) o_if ();

    serial_frame_rx #(.NBITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_        (in_),
        .deq        (o_if),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .drop_count (drop_count)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    int   nvec;
    int   nerr;
    int   fe_cnt;
    int   ov_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (o_if.out_val && o_if.out_rdy) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_word: got %0h, expected none",
                             o_if.out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", int'(o_if.out), int'(e.data));
                    check("out_perr", int'(o_if.out_perr), int'(e.perr));
                end
            end
        end
    end

    task automatic bit_(input logic b);
        in_ = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bit_(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip,
                              input logic stopb, input logic rdy_stop);
        bit_(1'b0);
        for (int i = 0; i < 8; i++) bit_(d[i]);
        bit_((^d) ^ pflip);
        if (rdy_stop) o_if.out_rdy = 1'b1;
        bit_(stopb);
        if (rdy_stop) o_if.out_rdy = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        fe_cnt = 0;
        ov_cnt = 0;
        check("rst_out", int'(o_if.out), 0);
        check("rst_perr", int'(o_if.out_perr), 0);
        check("rst_val", int'(o_if.out_val), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_ovr", int'(overrun), 0);
        check("rst_drop", int'(drop_count), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        o_if.out_rdy = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        idle(2);
        check("val_cleared", int'(o_if.out_val), 0);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        fe_cnt = 0;
        ov_cnt = 0;
        in_ = 1'b1;
        reset = 1'b1;
        o_if.out_rdy = 1'b0;

        // Basic good frame, then parity error frame
        do_reset();
        o_if.out_rdy = 1'b1;
        idle(1);
        exp_q.push_back('{8'hA5, 1'b0});
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        drain();
        exp_q.push_back('{8'hA5, 1'b1});
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        drain();
        check("s1_ferr_cnt", fe_cnt, 0);
        check("s1_drop", int'(drop_count), 0);

        // Frame error, zeros in WAIT_IDLE ignored
        do_reset();
        o_if.out_rdy = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        bit_(1'b0);
        bit_(1'b0);
        bit_(1'b0);
        bit_(1'b1);
        exp_q.push_back('{8'h3C, 1'b0});
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        drain();
        check("s2_ferr_cnt", fe_cnt, 1);
        check("s2_drop", int'(drop_count), 1);

        // Overrun with consumer stalled
        do_reset();
        o_if.out_rdy = 1'b0;
        exp_q.push_back('{8'h3C, 1'b0});
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        idle(2);
        check("s3_held_val", int'(o_if.out_val), 1);
        check("s3_held_out", int'(o_if.out), 8'h3C);
        check("s3_ovr_cnt", ov_cnt, 1);
        check("s3_drop", int'(drop_count), 1);
        drain();

        // Accept and completion in the same cycle
        do_reset();
        o_if.out_rdy = 1'b0;
        exp_q.push_back('{8'h3C, 1'b0});
        exp_q.push_back('{8'h81, 1'b0});
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        check("s4_next_val", int'(o_if.out_val), 1);
        check("s4_next_out", int'(o_if.out), 8'h81);
        check("s4_q_left", exp_q.size(), 1);
        idle(2);
        drain();
        check("s4_ovr_cnt", ov_cnt, 0);
        check("s4_drop", int'(drop_count), 0);

        // Reset in the middle of a frame
        do_reset();
        o_if.out_rdy = 1'b1;
        bit_(1'b0);
        bit_(1'b1);
        bit_(1'b1);
        bit_(1'b1);
        bit_(1'b1);
        reset = 1'b1;
        bit_(1'b1);
        reset = 1'b0;
        check("s5_rst_val", int'(o_if.out_val), 0);
        check("s5_rst_out", int'(o_if.out), 0);
        check("s5_rst_drop", int'(drop_count), 0);
        idle(1);
        exp_q.push_back('{8'h5A, 1'b0});
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        drain();
        check("s5_ferr_cnt", fe_cnt, 0);
        check("s5_ovr_cnt", ov_cnt, 0);
        check("s5_drop", int'(drop_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected done");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial frame receiver that consumes the registered one-bit stream produced by the single-bit DFF capture stage (its `q` drives this block's `in_`). It detects start bits, shifts in a fixed-width LSB-first data word, checks even parity and the stop bit, and presents each good frame on a one-entry latency-insensitive val/rdy output. Framing errors and dropped frames are flagged and counted so that downstream logic can monitor link health.

## Interface
- `NBITS`, default 8: data bits per frame; legal range 1 to 16.
- `clk` input 1: clock; all state updates on the posedge.
- `reset` input 1: synchronous, active-high reset.
- `in_` input 1: serial line, already registered by the upstream DFF stage; idles at 1.
- `out` output NBITS: received data word; valid only while `out_val` is 1.
- `out_perr` output 1: parity error flag accompanying `out`; valid only while `out_val` is 1.
- `out_val` output 1: output holds an undelivered word.
- `out_rdy` input 1: consumer accepts the word this cycle.
- `frame_err` output 1: one-cycle pulse when a stop bit is sampled as 0.
- `overrun` output 1: one-cycle pulse when a completed frame is dropped because the output is full.
- `drop_count` output 8: count of frames lost to overrun plus frame errors; saturates at 255.

## Operation
- Frame format, one bit per cycle: start (0), NBITS data bits LSB first, parity bit, stop (1).
- Parity is even: data bits plus parity bit contain an even number of 1s.
- States and transitions:
  - IDLE: `in_`=0 -> DATA, with the bit counter cleared. `in_`=1 -> stay in IDLE.
  - DATA: shift `in_` into bit position counter; after the NBITS-th bit -> PARITY.
  - PARITY: latch parity mismatch -> STOP.
  - STOP, `in_`=1: frame complete -> IDLE.
  - STOP, `in_`=0: pulse `frame_err` and discard the frame -> WAIT_IDLE.
  - WAIT_IDLE: stay until `in_`=1, then -> IDLE. A 0 sampled here is never treated as a start bit.
- Frame completion with output empty, or with `out_val && out_rdy` in the same cycle: load `out` and `out_perr`, and set `out_val`=1.
- Frame completion with `out_val && !out_rdy`: keep the held word unchanged, pulse `overrun`, and drop the new frame.
- Handshake: the word transfers on any cycle with `out_val && out_rdy`. If no new word loads that cycle, `out_val` clears on the next edge. `out` and `out_perr` stay stable while `out_val` is 1 and not accepted.
- A parity error does not drop the frame: the word is delivered with `out_perr`=1 and is not counted in `drop_count`.
- `drop_count` increments by 1 on each `overrun` or `frame_err` pulse (the two never coincide) and holds at 255.
- Reset values: state IDLE, `out`=0, `out_perr`=0, `out_val`=0, `frame_err`=0, `overrun`=0, `drop_count`=0, shift register and bit counter 0.
- Reset asserted mid-frame aborts the frame with no error pulse and no count.
- The output is fully registered. `in_` has no combinational path to any output, and `out_rdy` has no combinational path to any output.

## Timing
- Let cycle 0 be the cycle in which the start bit is sampled. Data bits are sampled in cycles 1..NBITS, parity in cycle NBITS+1 and stop in cycle NBITS+2.
- `out_val` rises in cycle NBITS+3, one cycle after the stop-bit edge. `frame_err` and `overrun` pulse in that same cycle.
- Back-to-back frames: a start bit may be sampled in the cycle immediately after a good stop bit, giving a sustained rate of one frame per NBITS+3 cycles.
- After a frame error, at least one idle 1 must be sampled before the next start bit is recognised.
- With `out_rdy` held at 1, the output never overruns at line rate.

## Test plan
- NBITS=8, reset then drive line 1,1,0,1,0,1,0,0,1,0,1,0,1 with `out_rdy`=1 -> after the stop bit, `out`=0xA5, `out_perr`=0 and `out_val`=1 for exactly one cycle; `drop_count`=0.
- Same frame with parity bit 1 -> `out`=0xA5, `out_perr`=1, `frame_err`=0, `drop_count`=0.
- 0xA5 frame with stop bit 0, then 0 held 3 cycles, then 1, then a 0x3C frame -> one `frame_err` pulse, no `out_val` for the first frame; the 0s during WAIT_IDLE are ignored; the next output is 0x3C; `drop_count`=1.
- `out_rdy`=0, back-to-back frames 0x3C then 0x81 -> `out` holds 0x3C with `out_val`=1; `overrun` pulses when the 0x81 frame completes; `drop_count`=1. Raising `out_rdy` then delivers 0x3C once, after which `out_val`=0.
- Simultaneous accept and completion: `out_rdy` pulsed 1 exactly in cycle NBITS+2 of the 0x81 frame while 0x3C is held -> 0x3C is accepted, `out`=0x81 on the next cycle with `out_val` staying 1, and no `overrun`.
- Assert `reset` during data bit 4 of a frame, then send a 0x5A frame -> all outputs return to their reset values; the only output is 0x5A with `out_perr`=0; `drop_count`=0.
